restoring_divider: RTL and testbench

Sequential unsigned restoring divider: the inverse operation of the team's sequential Booth multiplier, built as an FSM controller plus shift/subtract datapath in one module. It accepts an N-bit dividend and N-bit divisor on a start pulse and produces an N-bit quotient and N-bit remainder after one shift cycle and one subtract cycle per quotient bit. It is a stand-alone arithmetic unit for the course datapath and uses the same start/done handshake style as the multiplier.

---
 rtl/restoring_divider.sv | 106 ++++++++++
 tb/tb_restoring_divider.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one shift cycle and one subtract cycle per quotient bit,
// with a start/done handshake and a divide-by-zero flag.
module restoring_divider #(
    parameter int unsigned N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         done,
    output logic         dz,
    output logic         busy
);

    localparam int unsigned CntW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StShift, StSub, StDone} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    q_q, q_d;
    logic [N:0]      r_q, r_d;
    logic [N-1:0]    d_q, d_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            dz_q, dz_d;
    logic [N+1:0]    diff;

    // One extra bit so the sign of the trial subtraction is explicit.
    assign diff = {1'b0, r_q} - {2'b00, d_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    q_d   = dividend;
                    d_d   = divisor;
                    r_d   = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        dz_d    = 1'b1;
                        q_d     = '1;
                        r_d     = {1'b0, dividend};
                        state_d = StDone;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                r_d     = {r_q[N-1:0], q_q[N-1]};
                q_d     = {q_q[N-2:0], 1'b0};
                state_d = StSub;
            end
            StSub: begin
                // Negative trial difference: keep R (restore) and leave the quotient bit at 0.
                if (!diff[N+1]) begin
                    r_d    = diff[N:0];
                    q_d[0] = 1'b1;
                end
                if (cnt_q == CntW'(N - 1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                    state_d = StShift;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    assign quotient  = q_q;
    assign remainder = r_q[N-1:0];
    assign dz        = dz_q;
    assign done      = (state_q == StDone);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider (N=5): latency, handshake, reset abort, dz and full sweep.
module tb_restoring_divider;

    localparam int unsigned N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         done;
    logic         dz;
    logic         busy;

    int errors = 0;
    int checks = 0;

    restoring_divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .dz        (dz),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then wait (bounded) for done.
    // lat = cycles from the start cycle to the done cycle; bcnt = busy cycles seen up to done.
    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b,
                      output int lat, output int bcnt);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        bcnt  = 0;
        while (!done && lat < 40) begin
            bcnt += int'(busy);
            tick();
            lat++;
        end
        bcnt += int'(busy);
    endtask

    int lat, bcnt, ndone, first_done;
    int dcyc[$];

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        chk("reset_outputs", {quotient, remainder, done, dz, busy}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", {done, busy}, 32'd0);

        // 27/4: latency, busy length, result, hold in idle.
        op(5'd27, 5'd4, lat, bcnt);
        chk("27_4_latency", lat, 11);
        chk("27_4_busy_cycles", bcnt, 11);
        chk("27_4_result", {quotient, remainder, dz}, {5'd6, 5'd3, 1'b0});
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            ndone += int'(done);
            chk("27_4_idle_hold", {quotient, remainder, busy}, {5'd6, 5'd3, 1'b0});
        end
        chk("27_4_single_done", ndone, 0);

        op(5'd31, 5'd1, lat, bcnt);
        chk("31_1", {quotient, remainder, dz}, {5'd31, 5'd0, 1'b0});
        tick();
        op(5'd31, 5'd31, lat, bcnt);
        chk("31_31", {quotient, remainder, dz}, {5'd1, 5'd0, 1'b0});
        tick();
        op(5'd5, 5'd7, lat, bcnt);
        chk("5_7", {quotient, remainder, dz}, {5'd0, 5'd5, 1'b0});
        tick();

        // Divide by zero, then a normal op clears dz.
        op(5'd13, 5'd0, lat, bcnt);
        chk("13_0_latency", lat, 1);
        chk("13_0_busy_cycles", bcnt, 1);
        chk("13_0_result", {quotient, remainder, dz}, {5'd31, 5'd13, 1'b1});
        tick();
        chk("13_0_dz_held", {dz, busy, done}, {1'b1, 1'b0, 1'b0});
        op(5'd13, 5'd2, lat, bcnt);
        chk("13_2_result", {quotient, remainder, dz}, {5'd6, 5'd1, 1'b0});
        tick();

        // Start pulse while busy is ignored.
        dividend = 5'd20;
        divisor  = 5'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        dividend = 5'd9;
        divisor  = 5'd9;
        start    = 1'b1;
        tick();
        start      = 1'b0;
        ndone      = 0;
        first_done = -1;
        for (int c = 5; c <= 30; c++) begin
            if (done) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = c;
                    chk("20_3_result", {quotient, remainder, dz}, {5'd6, 5'd2, 1'b0});
                end
            end
            tick();
        end
        chk("busy_start_ignored_done_count", ndone, 1);
        chk("busy_start_ignored_done_cycle", first_done, 11);

        // Start held high: back-to-back operations every 12 cycles.
        dividend = 5'd27;
        divisor  = 5'd4;
        start    = 1'b1;
        tick();
        for (int c = 1; c <= 36; c++) begin
            if (done) begin
                dcyc.push_back(c);
                chk("held_start_result", {quotient, remainder}, {5'd6, 5'd3});
            end
            tick();
        end
        start = 1'b0;
        chk("held_start_done_count", dcyc.size(), 3);
        if (dcyc.size() == 3) begin
            chk("held_start_done0", dcyc[0], 11);
            chk("held_start_done1", dcyc[1], 23);
            chk("held_start_done2", dcyc[2], 35);
        end
        for (int i = 0; i < 14; i++) tick();
        chk("held_start_drained", {busy, done}, 32'd0);

        // Reset mid-operation aborts without a done pulse.
        dividend = 5'd27;
        divisor  = 5'd4;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        chk("mid_reset_outputs", {quotient, remainder, done, dz, busy}, 32'd0);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            ndone += int'(done) + int'(busy);
        end
        chk("mid_reset_no_done", ndone, 0);
        op(5'd17, 5'd5, lat, bcnt);
        chk("17_5_after_reset", {quotient, remainder, dz, lat[7:0]},
            {5'd3, 5'd2, 1'b0, 8'd11});
        tick();

        // Exhaustive sweep against the arithmetic model.
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                op(5'(a), 5'(b), lat, bcnt);
                if (b == 0)
                    chk($sformatf("sweep_dz_%0d", a), {quotient, remainder, dz, lat[7:0]},
                        {5'd31, 5'(a), 1'b1, 8'd1});
                else
                    chk($sformatf("sweep_%0d_%0d", a, b), {quotient, remainder, dz, lat[7:0]},
                        {5'(a / b), 5'(a % b), 1'b0, 8'd11});
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
